// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared types and constants for the Ethernet MAC datapath:
//               framer state encoding, preamble/SFD bytes and CRC-32 values.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
        ST_PAD  = 3'd4,
        ST_FCS  = 3'd5,
        ST_IFG  = 3'd6
    } state_t;

    localparam logic [7:0]  c_preamble_byte = 8'h55;
    localparam logic [7:0]  c_sfd_byte      = 8'hD5;
    localparam logic [31:0] c_crc_poly      = 32'hEDB88320;
    localparam logic [31:0] c_crc_init      = 32'hFFFFFFFF;
    // Register value left after running a good frame including its FCS
    localparam logic [31:0] c_crc_residue   = 32'hDEBB20E3;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
// Module      : crc32_d8
// Description : Combinational CRC-32 (reflected, poly 0xEDB88320) update for
//               one byte, LSB first. The caller owns the CRC register.
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8
    import mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    logic [31:0] w_acc;

    // Shift the eight data bits through the reflected LFSR, LSB first
    always_comb begin
        w_acc = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (w_acc[0] ^ d[i]) begin
                w_acc = (w_acc >> 1) ^ c_crc_poly;
            end else begin
                w_acc = w_acc >> 1;
            end
        end
        crc_out = w_acc;
    end

endmodule : crc32_d8
`default_nettype wire

// File: rtl/mac_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : mac_tx_framer
// Description : Ethernet MAC transmit framer. Wraps a raw frame with
//               preamble/SFD, zero-pads to a minimum length, appends the
//               CRC-32 FCS and enforces the inter-frame gap on a GMII-style
//               byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_tx_framer
    import mac_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_FRAME    = 60,
    parameter int unsigned IFG_LEN      = 12
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    output logic       o_busy,
    output logic       o_underrun
);

    localparam logic [7:0]  c_pre_last = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]  c_ifg_last = 8'(IFG_LEN - 1);
    localparam logic [15:0] c_min      = 16'(MIN_FRAME);

    state_t      r_state,      w_state_nxt;
    logic [7:0]  r_sub,        w_sub_nxt;      // preamble / FCS / IFG position
    logic [15:0] r_cnt,        w_cnt_nxt;      // data+pad bytes, saturating
    logic [31:0] r_crc,        w_crc_nxt;
    logic        r_bad,        w_bad_nxt;      // underrun: send raw crc as FCS
    logic        r_tx_valid,   w_tx_valid_nxt;
    logic [7:0]  r_tx_data,    w_tx_data_nxt;
    logic        r_underrun,   w_underrun_nxt;

    logic [15:0] w_cnt_inc;
    logic [7:0]  w_crc_byte;
    logic [31:0] w_crc_calc;
    logic [31:0] w_fcs_word;
    logic [7:0]  w_fcs_byte;

    assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_fcs_word = r_bad ? r_crc : ~r_crc;

    crc32_d8 u_crc (
        .crc_in  (r_crc),
        .d       (w_crc_byte),
        .crc_out (w_crc_calc)
    );

    // Next state, datapath updates and next output byte
    always_comb begin
        w_state_nxt    = r_state;
        w_sub_nxt      = r_sub;
        w_cnt_nxt      = r_cnt;
        w_crc_nxt      = r_crc;
        w_bad_nxt      = r_bad;
        w_tx_valid_nxt = 1'b0;
        w_tx_data_nxt  = 8'h00;
        w_underrun_nxt = 1'b0;
        w_crc_byte     = 8'h00;

        case (r_sub[1:0])
            2'd0:    w_fcs_byte = w_fcs_word[7:0];
            2'd1:    w_fcs_byte = w_fcs_word[15:8];
            2'd2:    w_fcs_byte = w_fcs_word[23:16];
            default: w_fcs_byte = w_fcs_word[31:24];
        endcase

        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_state_nxt = ST_PRE;
                    w_sub_nxt   = 8'd0;
                end
            end
            ST_PRE: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = c_preamble_byte;
                w_crc_nxt      = c_crc_init;
                w_cnt_nxt      = 16'd0;
                w_bad_nxt      = 1'b0;
                if (r_sub == c_pre_last) begin
                    w_state_nxt = ST_SFD;
                    w_sub_nxt   = 8'd0;
                end else begin
                    w_sub_nxt = r_sub + 8'd1;
                end
            end
            ST_SFD: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = c_sfd_byte;
                w_state_nxt    = ST_DATA;
            end
            ST_DATA: begin
                if (i_valid) begin
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = i_data;
                    w_crc_byte     = i_data;
                    w_crc_nxt      = w_crc_calc;
                    w_cnt_nxt      = w_cnt_inc;
                    if (i_last) begin
                        w_state_nxt = (w_cnt_inc < c_min) ? ST_PAD : ST_FCS;
                        w_sub_nxt   = 8'd0;
                    end
                end else begin
                    // Underrun: the crc register is already final, so the
                    // first (uncomplemented) FCS byte goes out this cycle and
                    // tx_valid never develops a hole.
                    w_underrun_nxt = 1'b1;
                    w_bad_nxt      = 1'b1;
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = r_crc[7:0];
                    w_state_nxt    = ST_FCS;
                    w_sub_nxt      = 8'd1;
                end
            end
            ST_PAD: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = 8'h00;
                w_crc_nxt      = w_crc_calc;
                w_cnt_nxt      = w_cnt_inc;
                if (w_cnt_inc >= c_min) begin
                    w_state_nxt = ST_FCS;
                    w_sub_nxt   = 8'd0;
                end
            end
            ST_FCS: begin
                w_tx_valid_nxt = 1'b1;
                w_tx_data_nxt  = w_fcs_byte;
                if (r_sub[1:0] == 2'd3) begin
                    w_state_nxt = ST_IFG;
                    w_sub_nxt   = 8'd0;
                end else begin
                    w_sub_nxt = r_sub + 8'd1;
                end
            end
            ST_IFG: begin
                if (r_sub == c_ifg_last) begin
                    w_sub_nxt   = 8'd0;
                    w_state_nxt = i_valid ? ST_PRE : ST_IDLE;
                end else begin
                    w_sub_nxt = r_sub + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sub_nxt   = 8'd0;
            end
        endcase
    end

    // State, counters, CRC and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_sub      <= 8'd0;
            r_cnt      <= 16'd0;
            r_crc      <= 32'd0;
            r_bad      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sub      <= w_sub_nxt;
            r_cnt      <= w_cnt_nxt;
            r_crc      <= w_crc_nxt;
            r_bad      <= w_bad_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    assign o_ready    = (r_state == ST_DATA);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_tx_valid = r_tx_valid;
    assign o_tx_data  = r_tx_data;
    assign o_underrun = r_underrun;

endmodule : mac_tx_framer
`default_nettype wire

// File: tb/tb_mac_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_tx_framer
// Description : Self-checking bench for mac_tx_framer. Two instances: index 0
//               with default parameters, index 1 with MIN_FRAME=9. Expected
//               byte streams come from a table-driven CRC-32 frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_tx_framer;

    localparam int IFG = 12;
    localparam int PRE = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0][7:0] din;
    logic [1:0]      vin, lin;
    logic [1:0]      ready, tx_valid, busy, underrun;
    logic [1:0][7:0] tx_data;

    always #4 clk = ~clk;

    mac_tx_framer u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din[0]), .i_valid(vin[0]),
        .i_last(lin[0]), .o_ready(ready[0]), .o_tx_data(tx_data[0]),
        .o_tx_valid(tx_valid[0]), .o_busy(busy[0]), .o_underrun(underrun[0])
    );

    mac_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(9), .IFG_LEN(12)) u_dut9 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din[1]), .i_valid(vin[1]),
        .i_last(lin[1]), .o_ready(ready[1]), .o_tx_data(tx_data[1]),
        .o_tx_valid(tx_valid[1]), .o_busy(busy[1]), .o_underrun(underrun[1])
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] crc_tab [256];
    logic [7:0]  src_q [$];
    logic        src_last [$];
    logic [7:0]  exp_q [$];
    logic        cap_v [$];
    logic [7:0]  cap_d [$];
    logic        cap_b [$];
    logic [7:0]  vb [$];
    int          n_ready, n_under;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        return crc_tab[(c[7:0] ^ b)] ^ (c >> 8);
    endfunction

    // Frame model: preamble, SFD, data, pad, FCS (raw crc when underrun)
    task automatic add_frame(input int len, input int minf, input int drop_after, input bit fixed);
        logic [7:0]  b;
        logic [31:0] c = 32'hFFFFFFFF;
        logic [31:0] f;
        for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < len; i++) begin
            b = fixed ? 8'(8'h31 + i) : 8'($urandom_range(0, 255));
            src_q.push_back(b);
            src_last.push_back(i == len - 1);
            if (drop_after < 0 || i < drop_after) begin
                exp_q.push_back(b);
                c = crc_upd(c, b);
            end
        end
        if (drop_after < 0) begin
            for (int i = len; i < minf; i++) begin
                exp_q.push_back(8'h00);
                c = crc_upd(c, 8'h00);
            end
            c = ~c;
        end
        for (int k = 0; k < 4; k++) begin
            f = c >> (8 * k);
            exp_q.push_back(f[7:0]);
        end
    endtask

    task automatic clear_all();
        src_q.delete(); src_last.delete(); exp_q.delete();
    endtask

    // Drive src_q into instance w, capture its outputs every cycle
    task automatic run(input int w, input int drop_after, input int rst_at);
        int idx = 0, acc = 0, cyc = 0, nv = 0;
        bit acc_pend = 0, dropped = 0, fin = 0;
        cap_v.delete(); cap_d.delete(); cap_b.delete();
        n_ready = 0; n_under = 0;
        while (cyc < 5000 && !fin) begin
            @(negedge clk);
            if (acc_pend) begin idx++; acc++; end
            if (drop_after >= 0 && acc == drop_after) dropped = 1;
            if (idx < src_q.size() && !dropped) begin
                din[w] = src_q[idx]; lin[w] = src_last[idx]; vin[w] = 1'b1;
            end else begin
                din[w] = 8'h00; lin[w] = 1'b0; vin[w] = 1'b0;
            end
            cap_v.push_back(tx_valid[w]);
            cap_d.push_back(tx_data[w]);
            cap_b.push_back(busy[w]);
            if (ready[w]) n_ready++;
            if (underrun[w]) n_under++;
            acc_pend = vin[w] && ready[w];
            if (tx_valid[w]) nv++;
            if (rst_at >= 0 && nv == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                chk_eq("rst_tx_valid", {31'd0, tx_valid[w]}, 32'd0);
                chk_eq("rst_tx_data", {24'd0, tx_data[w]}, 32'd0);
                chk_eq("rst_busy", {31'd0, busy[w]}, 32'd0);
                vin[w] = 1'b0; lin[w] = 1'b0; din[w] = 8'h00;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if ((idx >= src_q.size() || dropped) && !acc_pend && !busy[w]) fin = 1;
            cyc++;
        end
        if (!fin) chk_eq("run_timeout", 32'd1, 32'd0);
    endtask

    task automatic analyse(input string tag, input int frames, input int exp_ready, input int exp_under);
        int runs = 0, f_i = -1, l_i = -1, bad_idle = 0, busy_cnt = 0;
        int busy_low = -1, gap_bad = 0, prev_end = -1;
        vb.delete();
        for (int i = 0; i < cap_v.size(); i++) begin
            if (cap_b[i]) busy_cnt++;
            if (cap_v[i]) begin
                vb.push_back(cap_d[i]);
                if (f_i < 0) f_i = i;
                if (i == 0 || !cap_v[i-1]) begin
                    runs++;
                    if (prev_end >= 0 && (i - prev_end - 1) != IFG) gap_bad++;
                end
                if (i + 1 == cap_v.size() || !cap_v[i+1]) prev_end = i;
                l_i = i;
            end else if (cap_d[i] != 8'h00) begin
                bad_idle++;
            end
        end
        for (int i = l_i + 1; i < cap_v.size(); i++)
            if (!cap_b[i] && busy_low < 0) busy_low = i;
        chk_eq({tag, " nbytes"}, vb.size(), exp_q.size());
        for (int i = 0; i < vb.size() && i < exp_q.size(); i++)
            chk_eq($sformatf("%s byte%0d", tag, i), {24'd0, vb[i]}, {24'd0, exp_q[i]});
        chk_eq({tag, " idle_data_zero"}, bad_idle, 0);
        chk_eq({tag, " valid_runs"}, runs, frames);
        chk_eq({tag, " gap_len"}, gap_bad, 0);
        chk_eq({tag, " ifg_after"}, busy_low - l_i, IFG);
        chk_eq({tag, " busy_cycles"}, busy_cnt, l_i - f_i + 1 + IFG);
        chk_eq({tag, " ready_cycles"}, n_ready, exp_ready);
        chk_eq({tag, " underrun"}, n_under, exp_under);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = n;
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end
        rst_n = 1'b0; din = '0; vin = '0; lin = '0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk_eq("reset_tx_valid", {31'd0, tx_valid[w]}, 32'd0);
            chk_eq("reset_tx_data", {24'd0, tx_data[w]}, 32'd0);
            chk_eq("reset_ready", {31'd0, ready[w]}, 32'd0);
            chk_eq("reset_busy", {31'd0, busy[w]}, 32'd0);
            chk_eq("reset_underrun", {31'd0, underrun[w]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // "123456789" on MIN_FRAME=9 instance; FCS is the well-known check value
        clear_all(); add_frame(9, 9, -1, 1'b1);
        run(1, -1, -1); analyse("t1", 1, 9, 0);
        chk_eq("t1 nvalid", vb.size(), 21);
        if (vb.size() == 21) begin
            chk_eq("t1 fcs0", {24'd0, vb[17]}, 32'h26);
            chk_eq("t1 fcs1", {24'd0, vb[18]}, 32'h39);
            chk_eq("t1 fcs2", {24'd0, vb[19]}, 32'hF4);
            chk_eq("t1 fcs3", {24'd0, vb[20]}, 32'hCB);
        end

        // 14-byte frame, padded to 60
        clear_all(); add_frame(14, 60, -1, 1'b0);
        run(0, -1, -1); analyse("t2", 1, 14, 0);
        chk_eq("t2 nvalid", vb.size(), 72);

        // Single-byte frame on small instance, padded to 9
        clear_all(); add_frame(1, 9, -1, 1'b0);
        run(1, -1, -1); analyse("t1b", 1, 1, 0);

        // Back-to-back 64-byte frames with i_valid held
        clear_all(); add_frame(64, 60, -1, 1'b0); add_frame(64, 60, -1, 1'b0);
        run(0, -1, -1); analyse("t3", 2, 128, 0);

        // Underrun after 5 accepted bytes (ready also high on the empty beat)
        clear_all(); add_frame(10, 60, 5, 1'b0);
        run(0, 5, -1); analyse("t4", 1, 6, 1);

        // Reset while the third FCS byte is on the bus, then a clean frame
        clear_all(); add_frame(20, 60, -1, 1'b0);
        run(0, -1, PRE + 1 + 60 + 3);
        clear_all(); add_frame(30, 60, -1, 1'b0);
        run(0, -1, -1); analyse("t5", 1, 30, 0);

        // Long random frame, no pad
        clear_all(); add_frame(1500, 60, -1, 1'b0);
        run(0, -1, -1); analyse("t6", 1, 1500, 0);
        chk_eq("t6 nvalid", vb.size(), 1512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mac_tx_framer
`default_nettype wire
